// File: rtl/altera_nios2_qsys_be44pvus_oci_dct_packer.sv
// OCI data-compression-trace packer.
// Shifts 2-bit trace atoms into a live buffer and seals it into an output
// register when the buffer is full or a flush is requested. The sealed word
// is handed downstream over a valid/ready handshake.
module altera_nios2_qsys_be44pvus_oci_dct_packer #(
  parameter int ATOM_W  = 2,
  parameter int DEPTH   = 15,
  parameter int COUNT_W = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_trc_on,
  input  logic                      i_atom_valid,
  input  logic [ATOM_W-1:0]         i_atom_data,
  input  logic                      i_flush,
  input  logic                      i_overflow_clr,
  input  logic                      i_out_ready,
  output logic                      o_out_valid,
  output logic [ATOM_W*DEPTH-1:0]   o_out_buffer,
  output logic [COUNT_W-1:0]        o_out_count,
  output logic [ATOM_W*DEPTH-1:0]   o_dct_buffer,
  output logic [COUNT_W-1:0]        o_dct_count,
  output logic                      o_overflow
);

  localparam int BUF_W = ATOM_W * DEPTH;
  localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);

  logic [BUF_W-1:0]   r_dct_buffer;
  logic [COUNT_W-1:0] r_dct_count;
  logic [BUF_W-1:0]   r_out_buffer;
  logic [COUNT_W-1:0] r_out_count;
  logic               r_out_valid;
  logic               r_overflow;
  logic               r_flush_pending;

  logic w_free;
  logic w_full;
  logic w_nonempty;
  logic w_seal;
  logic w_atom_in;
  logic w_accept;
  logic w_drop;

  // The output register can take a new word when empty or being drained now.
  assign w_free     = !r_out_valid || i_out_ready;
  assign w_full     = (r_dct_count == FULL_CNT);
  assign w_nonempty = (r_dct_count != '0);
  assign w_seal     = w_free && w_nonempty && (w_full || i_flush || r_flush_pending);
  assign w_atom_in  = i_trc_on && i_atom_valid;
  // A full buffer can still accept an atom in the cycle it is sealed; the atom
  // then starts the next word rather than joining the sealed one.
  assign w_accept   = w_atom_in && (!w_full || w_seal);
  assign w_drop     = w_atom_in && w_full && !w_seal;

  // Live accumulation buffer: newest atom enters at the bottom.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dct_buffer <= '0;
      r_dct_count  <= '0;
    end else if (w_seal) begin
      if (w_accept) begin
        r_dct_buffer <= {{(BUF_W-ATOM_W){1'b0}}, i_atom_data};
        r_dct_count  <= COUNT_W'(1);
      end else begin
        r_dct_buffer <= '0;
        r_dct_count  <= '0;
      end
    end else if (w_accept) begin
      r_dct_buffer <= {r_dct_buffer[BUF_W-ATOM_W-1:0], i_atom_data};
      r_dct_count  <= r_dct_count + COUNT_W'(1);
    end
  end

  // Output register: load on seal, drop valid once drained, hold while blocked.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_out_buffer <= '0;
      r_out_count  <= '0;
      r_out_valid  <= 1'b0;
    end else if (w_seal) begin
      r_out_buffer <= r_dct_buffer;
      r_out_count  <= r_dct_count;
      r_out_valid  <= 1'b1;
    end else if (w_free) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Remember a flush that arrived while the output was blocked.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_flush_pending <= 1'b0;
    end else if (w_seal) begin
      r_flush_pending <= 1'b0;
    end else if (i_flush && !w_free && w_nonempty) begin
      r_flush_pending <= 1'b1;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_buffer = r_out_buffer;
  assign o_out_count  = r_out_count;
  assign o_dct_buffer = r_dct_buffer;
  assign o_dct_count  = r_dct_count;
  assign o_overflow   = r_overflow;

endmodule
